// File: rtl/trans_pkg.sv
// rtl/trans_pkg.sv - shared types for the translation request arbiter
package trans_pkg;

    typedef enum logic {
        REQ_INST = 1'b0,
        REQ_DATA = 1'b1
    } req_id_e;

    typedef struct packed {
        req_id_e id;
        logic    kill;
    } out_entry_t;

    localparam int TRANS_MAX_OUT_DEF = 2;

    function automatic req_id_e other_req(input req_id_e id);
        return (id == REQ_INST) ? REQ_DATA : REQ_INST;
    endfunction

endpackage

// File: rtl/trans_req_arbiter_if.sv
// rtl/trans_req_arbiter_if.sv - cache front-end and translator signals of the arbiter
interface trans_req_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              inst_req_valid;
    logic              inst_req_ready;
    logic [ADDR_W-1:0] inst_vaddr;
    logic              inst_flush;
    logic              inst_resp_valid;
    logic [ADDR_W-1:0] inst_resp_paddr;
    logic              inst_resp_uncache;

    logic              data_req_valid;
    logic              data_req_ready;
    logic [ADDR_W-1:0] data_vaddr;
    logic              data_cacop_di;
    logic              data_resp_valid;
    logic [ADDR_W-1:0] data_resp_paddr;
    logic              data_resp_uncache;

    logic              tr_req_valid;
    logic              tr_req_ready;
    logic [ADDR_W-1:0] tr_vaddr;
    logic              tr_cacop_di;
    logic              tr_resp_valid;
    logic [ADDR_W-1:0] tr_resp_paddr;
    logic              tr_resp_uncache;

    logic              busy;
    logic              err;

    // slave: the arbiter itself
    modport slave (
        input  inst_req_valid, inst_vaddr, inst_flush,
        input  data_req_valid, data_vaddr, data_cacop_di,
        input  tr_req_ready, tr_resp_valid, tr_resp_paddr, tr_resp_uncache,
        output inst_req_ready, inst_resp_valid, inst_resp_paddr, inst_resp_uncache,
        output data_req_ready, data_resp_valid, data_resp_paddr, data_resp_uncache,
        output tr_req_valid, tr_vaddr, tr_cacop_di,
        output busy, err
    );

    // master: the surrounding caches and translator
    modport master (
        output inst_req_valid, inst_vaddr, inst_flush,
        output data_req_valid, data_vaddr, data_cacop_di,
        output tr_req_ready, tr_resp_valid, tr_resp_paddr, tr_resp_uncache,
        input  inst_req_ready, inst_resp_valid, inst_resp_paddr, inst_resp_uncache,
        input  data_req_ready, data_resp_valid, data_resp_paddr, data_resp_uncache,
        input  tr_req_valid, tr_vaddr, tr_cacop_di,
        input  busy, err
    );

endinterface

// File: rtl/trans_id_fifo.sv
// rtl/trans_id_fifo.sv - in-order requester-ID FIFO of outstanding translator lookups
module trans_id_fifo
    import trans_pkg::*;
#(
    parameter  int DEPTH = TRANS_MAX_OUT_DEF,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  out_entry_t       push_entry_i,
    input  logic             pop_i,
    input  logic             kill_inst_i,
    output out_entry_t       head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    out_entry_t       mem_q [DEPTH];
    out_entry_t       mem_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        mem_d    = mem_q;
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_inst_i && vld_q[i] && (mem_q[i].id == REQ_INST)) begin
                mem_d[i].kill = 1'b1;
            end
        end
        if (do_pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = ptr_inc(rd_ptr_q);
        end
        if (do_push) begin
            mem_d[wr_ptr_q] = push_entry_i;
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/trans_req_arbiter.sv
// rtl/trans_req_arbiter.sv - round-robin sharing of one translation port between ICache and DCache
module trans_req_arbiter
    import trans_pkg::*;
#(
    parameter int MAX_OUT = TRANS_MAX_OUT_DEF,
    parameter int ADDR_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    trans_req_arbiter_if.slave   bus
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic              lock_q, lock_d;
    req_id_e           lock_id_q, lock_id_d;
    req_id_e           rr_q, rr_d;
    logic              err_q, err_d;

    req_id_e           win_id;
    logic              win_valid;
    logic [ADDR_W-1:0] win_vaddr;
    logic              win_cacop_di;
    logic              can_issue;
    logic              req_fire;
    logic              handshake;
    logic              pop;

    out_entry_t        push_entry;
    out_entry_t        head;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;

    always_comb begin
        win_id = rr_q;
        if (lock_q) begin
            win_id = lock_id_q;
        end else if (bus.inst_req_valid && !bus.data_req_valid) begin
            win_id = REQ_INST;
        end else if (bus.data_req_valid && !bus.inst_req_valid) begin
            win_id = REQ_DATA;
        end
    end

    assign win_valid    = (win_id == REQ_DATA) ? bus.data_req_valid : bus.inst_req_valid;
    assign win_vaddr    = (win_id == REQ_DATA) ? bus.data_vaddr : bus.inst_vaddr;
    assign win_cacop_di = (win_id == REQ_DATA) && bus.data_cacop_di;

    // A response in the same cycle frees a slot, so a full FIFO can still issue.
    assign can_issue = !full || bus.tr_resp_valid;
    assign req_fire  = rst && can_issue && win_valid;
    assign handshake = req_fire && bus.tr_req_ready;
    assign pop       = rst && bus.tr_resp_valid && !empty;

    assign push_entry.id   = win_id;
    assign push_entry.kill = (win_id == REQ_INST) && bus.inst_flush;

    trans_id_fifo #(
        .DEPTH (MAX_OUT)
    ) u_id_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (handshake),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .kill_inst_i  (bus.inst_flush),
        .head_o       (head),
        .count_o      (count),
        .full_o       (full),
        .empty_o      (empty)
    );

    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        rr_d      = rr_q;
        err_d     = err_q;
        if (handshake) begin
            lock_d = 1'b0;
            rr_d   = other_req(win_id);
        end else if (req_fire) begin
            lock_d    = 1'b1;
            lock_id_d = win_id;
        end
        if (bus.tr_resp_valid && empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_q    <= 1'b0;
            lock_id_q <= REQ_DATA;
            rr_q      <= REQ_DATA;
            err_q     <= 1'b0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            rr_q      <= rr_d;
            err_q     <= err_d;
        end
    end

    assign bus.tr_req_valid   = req_fire;
    assign bus.tr_vaddr       = win_vaddr;
    assign bus.tr_cacop_di    = win_cacop_di;
    assign bus.inst_req_ready = handshake && (win_id == REQ_INST);
    assign bus.data_req_ready = handshake && (win_id == REQ_DATA);

    // Killed INST entries and INST results arriving during a flush are dropped silently.
    assign bus.inst_resp_valid   = pop && (head.id == REQ_INST) && !head.kill && !bus.inst_flush;
    assign bus.inst_resp_paddr   = bus.tr_resp_paddr;
    assign bus.inst_resp_uncache = bus.tr_resp_uncache;
    assign bus.data_resp_valid   = pop && (head.id == REQ_DATA);
    assign bus.data_resp_paddr   = bus.tr_resp_paddr;
    assign bus.data_resp_uncache = bus.tr_resp_uncache;

    assign bus.busy = (count != '0) || lock_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_trans_req_arbiter.sv
// tb/tb_trans_req_arbiter.sv - directed self-checking bench for trans_req_arbiter
module tb_trans_req_arbiter;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    trans_req_arbiter_if #(.ADDR_W(32)) bus ();

    trans_req_arbiter #(
        .MAX_OUT (2),
        .ADDR_W  (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [31:0] ia, input logic dv, input logic [31:0] da,
                         input logic di, input logic rdy, input logic rv, input logic [31:0] rp,
                         input logic ru, input logic fl);
        bus.inst_req_valid  = iv;
        bus.inst_vaddr      = ia;
        bus.data_req_valid  = dv;
        bus.data_vaddr      = da;
        bus.data_cacop_di   = di;
        bus.tr_req_ready    = rdy;
        bus.tr_resp_valid   = rv;
        bus.tr_resp_paddr   = rp;
        bus.tr_resp_uncache = ru;
        bus.inst_flush      = fl;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 1, 32'h0000_1234, 0, 1, 0, 0, 0, 0);
        chk("rst_tr_req_valid", bus.tr_req_valid, 0);
        chk("rst_data_ready", bus.data_req_ready, 0);
        chk("rst_inst_ready", bus.inst_req_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err, 0);
        step();
        step();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Round robin, both requesters always valid, response one cycle later
        step(); drive(1, 32'h0000_1000, 1, 32'h0000_2000, 0, 1, 0, 0, 0, 0);
        chk("rr0_data_ready", bus.data_req_ready, 1);
        chk("rr0_inst_ready", bus.inst_req_ready, 0);
        chk("rr0_tr_vaddr", bus.tr_vaddr, 32'h0000_2000);
        step(); drive(1, 32'h0000_1000, 1, 32'h0000_2000, 0, 1, 1, 32'hA000_2000, 0, 0);
        chk("rr1_inst_ready", bus.inst_req_ready, 1);
        chk("rr1_data_ready", bus.data_req_ready, 0);
        chk("rr1_tr_vaddr", bus.tr_vaddr, 32'h0000_1000);
        chk("rr1_data_resp_valid", bus.data_resp_valid, 1);
        chk("rr1_data_resp_paddr", bus.data_resp_paddr, 32'hA000_2000);
        step(); drive(1, 32'h0000_1000, 1, 32'h0000_2000, 0, 1, 1, 32'hA000_1000, 1, 0);
        chk("rr2_data_ready", bus.data_req_ready, 1);
        chk("rr2_inst_resp_valid", bus.inst_resp_valid, 1);
        chk("rr2_inst_resp_paddr", bus.inst_resp_paddr, 32'hA000_1000);
        chk("rr2_inst_resp_uncache", bus.inst_resp_uncache, 1);
        chk("rr2_data_resp_valid", bus.data_resp_valid, 0);
        step(); drive(1, 32'h0000_1000, 1, 32'h0000_2000, 0, 1, 1, 32'hA000_2000, 0, 0);
        chk("rr3_inst_ready", bus.inst_req_ready, 1);
        chk("rr3_data_resp_valid", bus.data_resp_valid, 1);
        step(); drive(0, 0, 0, 0, 0, 1, 1, 32'hA000_1000, 0, 0);
        chk("rr4_tr_req_valid", bus.tr_req_valid, 0);
        chk("rr4_inst_resp_valid", bus.inst_resp_valid, 1);
        step(); drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("rr5_busy", bus.busy, 0);

        // Translator stall holds the DATA grant for three cycles
        step(); drive(1, 32'h0000_1000, 1, 32'h0000_2000, 1, 0, 0, 0, 0, 0);
        chk("st0_tr_req_valid", bus.tr_req_valid, 1);
        chk("st0_tr_vaddr", bus.tr_vaddr, 32'h0000_2000);
        chk("st0_tr_cacop_di", bus.tr_cacop_di, 1);
        chk("st0_inst_ready", bus.inst_req_ready, 0);
        chk("st0_data_ready", bus.data_req_ready, 0);
        step(); drive(1, 32'h0000_1000, 1, 32'h0000_2000, 1, 0, 0, 0, 0, 0);
        chk("st1_busy_locked", bus.busy, 1);
        chk("st1_tr_vaddr", bus.tr_vaddr, 32'h0000_2000);
        chk("st1_inst_ready", bus.inst_req_ready, 0);
        step(); drive(1, 32'h0000_1000, 1, 32'h0000_2000, 1, 0, 0, 0, 0, 0);
        chk("st2_tr_vaddr", bus.tr_vaddr, 32'h0000_2000);
        chk("st2_inst_ready", bus.inst_req_ready, 0);
        step(); drive(1, 32'h0000_1000, 1, 32'h0000_2000, 1, 1, 0, 0, 0, 0);
        chk("st3_data_ready", bus.data_req_ready, 1);
        chk("st3_inst_ready", bus.inst_req_ready, 0);
        step(); drive(1, 32'h0000_1000, 1, 32'h0000_2004, 0, 1, 0, 0, 0, 0);
        chk("st4_inst_ready", bus.inst_req_ready, 1);
        chk("st4_data_ready", bus.data_req_ready, 0);
        chk("st4_tr_cacop_di", bus.tr_cacop_di, 0);
        step(); drive(0, 0, 1, 32'h0000_2004, 0, 1, 1, 32'hB000_2000, 0, 0);
        chk("st5_data_resp_valid", bus.data_resp_valid, 1);
        chk("st5_data_ready", bus.data_req_ready, 1);
        step(); drive(0, 0, 0, 0, 0, 1, 1, 32'hB000_1000, 0, 0);
        chk("st6_inst_resp_valid", bus.inst_resp_valid, 1);
        step(); drive(0, 0, 0, 0, 0, 1, 1, 32'hB000_2004, 0, 0);
        chk("st7_data_resp_valid", bus.data_resp_valid, 1);
        step(); drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("st8_busy", bus.busy, 0);

        // Single data request, response two cycles later
        step(); drive(0, 0, 1, 32'h1C00_0040, 0, 1, 0, 0, 0, 0);
        chk("sd0_data_ready", bus.data_req_ready, 1);
        chk("sd0_tr_vaddr", bus.tr_vaddr, 32'h1C00_0040);
        step(); drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("sd1_data_resp_valid", bus.data_resp_valid, 0);
        chk("sd1_busy", bus.busy, 1);
        step(); drive(0, 0, 0, 0, 0, 1, 1, 32'h1C00_0040, 0, 0);
        chk("sd2_data_resp_valid", bus.data_resp_valid, 1);
        chk("sd2_data_resp_paddr", bus.data_resp_paddr, 32'h1C00_0040);
        chk("sd2_data_resp_uncache", bus.data_resp_uncache, 0);
        chk("sd2_inst_resp_valid", bus.inst_resp_valid, 0);
        step(); drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("sd3_data_resp_valid", bus.data_resp_valid, 0);
        chk("sd3_busy", bus.busy, 0);

        // Fill both slots, then pop and push in the same cycle
        step(); drive(0, 0, 1, 32'h0000_3000, 0, 1, 0, 0, 0, 0);
        chk("fl0_data_ready", bus.data_req_ready, 1);
        step(); drive(0, 0, 1, 32'h0000_3004, 0, 1, 0, 0, 0, 0);
        chk("fl1_data_ready", bus.data_req_ready, 1);
        step(); drive(0, 0, 1, 32'h0000_3008, 0, 1, 0, 0, 0, 0);
        chk("fl2_tr_req_valid_full", bus.tr_req_valid, 0);
        chk("fl2_data_ready", bus.data_req_ready, 0);
        step(); drive(0, 0, 1, 32'h0000_3008, 0, 1, 1, 32'h9000_3000, 0, 0);
        chk("fl3_data_resp_valid", bus.data_resp_valid, 1);
        chk("fl3_data_resp_paddr", bus.data_resp_paddr, 32'h9000_3000);
        chk("fl3_data_ready", bus.data_req_ready, 1);
        chk("fl3_tr_vaddr", bus.tr_vaddr, 32'h0000_3008);
        step(); drive(1, 32'h0000_4000, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("fl4_tr_req_valid_still_full", bus.tr_req_valid, 0);
        step(); drive(1, 32'h0000_4000, 0, 0, 0, 1, 1, 32'h9000_3004, 0, 0);
        chk("fl5_data_resp_valid", bus.data_resp_valid, 1);
        chk("fl5_inst_ready", bus.inst_req_ready, 1);
        step(); drive(0, 0, 0, 0, 0, 1, 1, 32'h9000_3008, 0, 0);
        chk("fl6_data_resp_valid", bus.data_resp_valid, 1);
        step(); drive(0, 0, 0, 0, 0, 1, 1, 32'h9000_4000, 0, 0);
        chk("fl7_inst_resp_valid", bus.inst_resp_valid, 1);
        step(); drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("fl8_busy", bus.busy, 0);

        // Flush kills the outstanding INST lookup only
        step(); drive(1, 32'h0000_5000, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("fs0_inst_ready", bus.inst_req_ready, 1);
        step(); drive(0, 0, 1, 32'h0000_6000, 0, 1, 0, 0, 0, 0);
        chk("fs1_data_ready", bus.data_req_ready, 1);
        step(); drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        chk("fs2_busy", bus.busy, 1);
        step(); drive(0, 0, 0, 0, 0, 1, 1, 32'h8000_5000, 0, 0);
        chk("fs3_inst_resp_valid", bus.inst_resp_valid, 0);
        chk("fs3_data_resp_valid", bus.data_resp_valid, 0);
        step(); drive(0, 0, 0, 0, 0, 1, 1, 32'h8000_6000, 0, 0);
        chk("fs4_data_resp_valid", bus.data_resp_valid, 1);
        chk("fs4_data_resp_paddr", bus.data_resp_paddr, 32'h8000_6000);
        chk("fs4_inst_resp_valid", bus.inst_resp_valid, 0);
        step(); drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("fs5_busy", bus.busy, 0);
        chk("fs5_err", bus.err, 0);

        // Spurious response with an empty FIFO
        step(); drive(0, 0, 0, 0, 0, 1, 1, 32'hDEAD_0000, 0, 0);
        chk("sp0_data_resp_valid", bus.data_resp_valid, 0);
        chk("sp0_inst_resp_valid", bus.inst_resp_valid, 0);
        step(); drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("sp1_err", bus.err, 1);

        // Asynchronous reset in the middle of a stalled request
        step(); drive(0, 0, 1, 32'h0000_7000, 0, 0, 0, 0, 0, 0);
        chk("ar0_tr_req_valid", bus.tr_req_valid, 1);
        step(); drive(0, 0, 1, 32'h0000_7000, 0, 0, 0, 0, 0, 0);
        chk("ar1_busy", bus.busy, 1);
        rst = 1'b0;
        #1;
        chk("ar2_tr_req_valid", bus.tr_req_valid, 0);
        chk("ar2_data_ready", bus.data_req_ready, 0);
        chk("ar2_busy", bus.busy, 0);
        chk("ar2_err", bus.err, 0);
        step();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("ar3_err", bus.err, 0);
        chk("ar3_busy", bus.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trans_req_arbiter.md
Name: trans_req_arbiter

Overview:
- Shares one address-translation port between the ICache fetch requester and the DCache data requester.
- Arbitrates round-robin, holds a grant while the translator stalls, and tracks in-order outstanding lookups in a requester-ID FIFO.
- Routes each translated paddr/uncache result back to the requester that issued it.
- Drops stale instruction results after an ICache flush.
- Sits between the cache front-ends and the translation unit.

Parameters:
- MAX_OUT, 2, maximum translator lookups in flight (1..4).
- ADDR_W, 32, virtual/physical address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, active-low, asynchronous
- inst_req_valid  in  1  ICache lookup request
- inst_req_ready  out  1  ICache request accepted this cycle
- inst_vaddr  in  ADDR_W  ICache virtual address
- inst_flush  in  1  ICache flush; kills in-flight inst lookups
- inst_resp_valid  out  1  inst translation result valid
- inst_resp_paddr  out  ADDR_W  inst physical address
- inst_resp_uncache  out  1  inst uncached attribute
- data_req_valid  in  1  DCache lookup request
- data_req_ready  out  1  DCache request accepted this cycle
- data_vaddr  in  ADDR_W  DCache virtual address
- data_cacop_di  in  1  CACOP direct-index mode (bypasses DMW mapping)
- data_resp_valid  out  1  data translation result valid
- data_resp_paddr  out  ADDR_W  data physical address
- data_resp_uncache  out  1  data uncached attribute
- tr_req_valid  out  1  request to translator
- tr_req_ready  in  1  translator accepts
- tr_vaddr  out  ADDR_W  forwarded vaddr
- tr_cacop_di  out  1  forwarded cacop_di; 0 for inst
- tr_resp_valid  in  1  translator result (in order, always accepted)
- tr_resp_paddr  in  ADDR_W  translated address
- tr_resp_uncache  in  1  uncached attribute
- busy  out  1  FIFO non-empty or grant locked
- err  out  1  sticky protocol error

Behaviour:
- Reset (rst low, async):
  - FIFO empty, count 0, lock cleared.
  - RR pointer = DATA.
  - err = 0.
  - All valid/ready outputs 0. Payload outputs are don't-care.
- Requester rule: once valid is raised, the requester holds valid and payload stable until ready.
- can_issue = (count < MAX_OUT) OR tr_resp_valid (pop frees a slot the same cycle).
- Grant is combinational, one-hot:
  - If lock is set, the locked ID wins.
  - Otherwise, if exactly one requester is valid, it wins.
  - If both are valid, the RR pointer's requester wins.
- tr_req_valid = can_issue AND valid of the granted requester. tr_vaddr and tr_cacop_di are muxed from the winner.
- The winner's ready = tr_req_valid AND tr_req_ready. The loser's ready = 0.
- Stall handling:
  - If tr_req_valid AND NOT tr_req_ready, set lock to the winner ID for the next cycle.
  - Clear lock on handshake.
  - The grant cannot switch while the translator stalls.
- On handshake:
  - Push {id, kill} into the FIFO.
  - Set the RR pointer to the other requester.
- FIFO is a MAX_OUT-entry circular buffer:
  - wr_ptr/rd_ptr wrap modulo MAX_OUT.
  - Simultaneous push and pop leaves count unchanged.
- Response routing, on tr_resp_valid with the FIFO non-empty:
  - Pop the head entry.
  - If the head ID is DATA, assert data_resp_valid.
  - If the head ID is INST and not killed, and inst_flush is low this cycle, assert inst_resp_valid.
  - Result payload outputs pass tr_resp_* combinationally (zero added latency).
- tr_resp_valid with the FIFO empty: ignored, no pop, err set to 1 until reset.
- inst_flush:
  - Sets the kill bit on every valid INST entry in the FIFO.
  - Also kills an INST entry pushed in the same cycle.
  - Does not affect data entries.
  - Does not affect a pending, not-yet-accepted inst request, which is issued normally and is not killed unless flushed again.
- Killed entries are popped silently with no resp_valid.
- busy = (count != 0) OR lock.

Decomposition:
- Shared package (trans_pkg):
  - typedef req_id_e {REQ_INST = 0, REQ_DATA = 1}.
  - struct out_entry_t {req_id_e id; logic kill}.
  - Constant TRANS_MAX_OUT_DEF = 2.
- One sub-module, trans_id_fifo:
  - Parameterised circular FIFO of out_entry_t.
  - Has a kill_inst input that marks all INST entries.
  - Exposes count/full/empty.
- Arbitration and lock logic stay in the top module.

Test Plan:
- Single data request, vaddr 0x1C00_0040, tr_req_ready = 1, response paddr 0x1C00_0040 / uncache 0 two cycles later -> data_resp_valid for exactly one cycle with that paddr; inst_resp_valid stays 0.
- Both requesters valid every cycle, translator always ready, response 1 cycle after each request -> grants alternate DATA, INST, DATA, INST…; no requester waits more than 1 cycle.
- Grant stalled: both valid, tr_req_ready low 3 cycles -> tr_vaddr stays equal to data_vaddr and inst_req_ready stays 0 throughout; handshake occurs in cycle 4; INST is granted next.
- MAX_OUT = 2 fill: two accepted requests with no response -> tr_req_valid = 0. Then tr_resp_valid with a new request waiting -> pop and push in the same cycle; count stays 2.
- Flush: INST then DATA outstanding, inst_flush pulsed, then two responses -> inst_resp_valid never asserts; data_resp_valid asserts once with the second paddr.
- Spurious tr_resp_valid with an empty FIFO -> no resp_valid and err = 1. Asynchronous rst low mid-transaction -> all outputs cleared immediately; err = 0 after reset.
